// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic result path.
//  - MODE_* : post-process selectors carried alongside each frame
//  - BYTES_PER_FRAME / ELEMS_PER_FRAME : frame geometry (2x2 result, 16-bit elems)
//  - elem_t / frame_t : one element, one packed frame (element k at [k])
//  - asm_state_t : result byte assembler states
//  - post_proc() : ReLU / int8 saturation applied to one signed element
package tpu_pkg;

   localparam logic [1:0] MODE_RAW      = 2'd0;
   localparam logic [1:0] MODE_RELU     = 2'd1;
   localparam logic [1:0] MODE_SAT      = 2'd2;
   localparam logic [1:0] MODE_RELU_SAT = 2'd3;

   localparam int BYTES_PER_FRAME = 8;
   localparam int ELEMS_PER_FRAME = 4;

   typedef logic [15:0] elem_t;
   typedef elem_t [ELEMS_PER_FRAME-1:0] frame_t;

   typedef enum logic {A_IDLE, A_COLLECT} asm_state_t;

   // ReLU runs before the clamp, so mode 3 lands in [0,127].
   function automatic elem_t post_proc(input elem_t x, input logic [1:0] mode);
      logic signed [15:0] v;
      logic               relu, sat;
      v    = signed'(x);
      relu = (mode == MODE_RELU) || (mode == MODE_RELU_SAT);
      sat  = (mode == MODE_SAT)  || (mode == MODE_RELU_SAT);
      if (mode == MODE_RAW) return x;
      if (relu && (v < 16'sd0)) v = 16'sd0;
      if (sat) begin
         if (v > 16'sd127)       v = 16'sd127;
         else if (v < -16'sd128) v = -16'sd128;
      end
      return elem_t'(v);
   endfunction

endpackage

// File: rtl/result_drain_if.sv
// Byte-in / element-out stream bundle of the result drain.
//  in_valid/in_first/in_byte/mode : result bytes from the control unit
//  out_valid/out_ready            : host element handshake
//  out_data/out_idx/out_last      : element value, index 0..3, last-of-frame
// master = producer/host side, slave = result_drain.
interface result_drain_if;
   import tpu_pkg::*;

   logic        in_valid;
   logic        in_first;
   logic [7:0]  in_byte;
   logic [1:0]  mode;
   logic        out_valid;
   logic        out_ready;
   elem_t       out_data;
   logic [1:0]  out_idx;
   logic        out_last;

   modport master (
      output in_valid, in_first, in_byte, mode, out_ready,
      input  out_valid, out_data, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_first, in_byte, mode, out_ready,
      output out_valid, out_data, out_idx, out_last
   );

endinterface

// File: rtl/result_frame_fifo.sv
// Whole-frame FIFO with per-element read-out.
//  clk, rst_n : clock, synchronous active-low reset (pointers only)
//  push, push_frame : frame write request (dropped when full, see drop)
//  pop        : one element consumed from the head
//  drop       : push refused this cycle
//  nxt_vld/nxt_elem/nxt_idx : head view after this cycle's pop, before this
//                             cycle's push -- the caller registers it, which
//                             gives the one-cycle push-to-visible latency.
module result_frame_fifo
   import tpu_pkg::*;
#(
   parameter int FRAMES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  frame_t     push_frame,
   input  logic       pop,
   output logic       drop,
   output logic       nxt_vld,
   output elem_t      nxt_elem,
   output logic [1:0] nxt_idx
);

   localparam int AW = $clog2(FRAMES);
   localparam logic [AW:0] PTR_ONE = 1;

   // frame pointers carry a wrap bit so full and empty are distinguishable
   logic [AW:0] wr_ptr, rd_ptr, rd_nxt;
   logic [1:0]  elem_ptr;
   frame_t      mem [FRAMES];

   logic empty, full, pop_ok, head_rel, push_ok;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok   = pop && !empty;
   assign head_rel = pop_ok && (elem_ptr == 2'd3);
   // the slot freed by the final beat can take a new frame on the same edge
   assign push_ok  = push && (!full || head_rel);
   assign drop     = push && !push_ok;

   assign rd_nxt   = head_rel ? rd_ptr + PTR_ONE : rd_ptr;
   assign nxt_idx  = pop_ok ? elem_ptr + 2'd1 : elem_ptr;
   // wr_ptr is the pre-push value: a frame written now is not visible yet
   assign nxt_vld  = (wr_ptr != rd_nxt);
   assign nxt_elem = mem[rd_nxt[AW-1:0]][nxt_idx];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         elem_ptr <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         rd_ptr   <= rd_nxt;
         elem_ptr <= nxt_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_frame;
   end

endmodule

// File: rtl/result_drain.sv
// Result drain: reassembles 8-byte result frames into four signed 16-bit
// elements, post-processes them, buffers whole frames and streams them to
// the host one element per beat.
//  clk, rst_n : clock, synchronous active-low reset
//  bus        : result_drain_if.slave (byte input stream, element output stream)
//  clr_err    : clears ovf/ferr (a same-cycle set wins)
//  ovf        : sticky, a completed frame was dropped on a full FIFO
//  ferr       : sticky, a frame restarted before all 8 bytes arrived
module result_drain
   import tpu_pkg::*;
#(
   parameter int FRAMES = 2,
   parameter int OUT_W  = 16
) (
   input  logic clk,
   input  logic rst_n,
   result_drain_if.slave bus,
   input  logic clr_err,
   output logic ovf,
   output logic ferr
);

   // ---------------- assembler ----------------
   asm_state_t      st;
   logic [2:0]      cnt;
   logic [6:0][7:0] byte_q;     // bytes 0..6; byte 7 is taken straight off the bus
   logic [1:0]      frm_mode;

   logic   take_first, frame_done, ferr_set;
   frame_t raw, pp;

   assign take_first = bus.in_valid && bus.in_first;
   assign frame_done = (st == A_COLLECT) && bus.in_valid && !bus.in_first && (cnt == 3'd7);
   assign ferr_set   = take_first && (st == A_COLLECT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st       <= A_IDLE;
         cnt      <= 3'd0;
         byte_q   <= '0;
         frm_mode <= MODE_RAW;
      end else begin
         case (st)
            A_IDLE: begin
               if (take_first) begin
                  byte_q[0] <= bus.in_byte;
                  cnt       <= 3'd1;
                  frm_mode  <= bus.mode;
                  st        <= A_COLLECT;
               end
            end
            A_COLLECT: begin
               if (take_first) begin
                  // restart: the partial frame is abandoned
                  byte_q[0] <= bus.in_byte;
                  cnt       <= 3'd1;
                  frm_mode  <= bus.mode;
               end else if (bus.in_valid) begin
                  if (cnt == 3'd7) begin
                     cnt <= 3'd0;
                     st  <= A_IDLE;
                  end else begin
                     byte_q[cnt] <= bus.in_byte;
                     cnt         <= cnt + 3'd1;
                  end
               end
            end
            default: st <= A_IDLE;
         endcase
      end
   end

   // hi byte first: elem k = {byte 2k, byte 2k+1}
   always_comb begin
      raw[0] = {byte_q[0], byte_q[1]};
      raw[1] = {byte_q[2], byte_q[3]};
      raw[2] = {byte_q[4], byte_q[5]};
      raw[3] = {byte_q[6], bus.in_byte};
      pp[0]  = post_proc(raw[0], frm_mode);
      pp[1]  = post_proc(raw[1], frm_mode);
      pp[2]  = post_proc(raw[2], frm_mode);
      pp[3]  = post_proc(raw[3], frm_mode);
   end

   // ---------------- frame FIFO ----------------
   logic       pop, drop, nxt_vld;
   elem_t      nxt_elem;
   logic [1:0] nxt_idx;

   assign pop = bus.out_valid && bus.out_ready;

   result_frame_fifo #(.FRAMES(FRAMES)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (frame_done),
      .push_frame (pp),
      .pop        (pop),
      .drop       (drop),
      .nxt_vld    (nxt_vld),
      .nxt_elem   (nxt_elem),
      .nxt_idx    (nxt_idx)
   );

   // ---------------- registered output ----------------
   logic             vld_q, last_q;
   logic [OUT_W-1:0] data_q;
   logic [1:0]       idx_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         data_q <= '0;
         idx_q  <= 2'd0;
         last_q <= 1'b0;
      end else begin
         // with no handshake the FIFO head view is unchanged, so these hold
         vld_q  <= nxt_vld;
         data_q <= nxt_vld ? nxt_elem : '0;
         idx_q  <= nxt_vld ? nxt_idx : 2'd0;
         last_q <= nxt_vld && (nxt_idx == 2'd3);
      end
   end

   assign bus.out_valid = vld_q;
   assign bus.out_data  = data_q;
   assign bus.out_idx   = idx_q;
   assign bus.out_last  = last_q;

   // ---------------- sticky flags ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf  <= 1'b0;
         ferr <= 1'b0;
      end else begin
         ovf  <= drop     | (ovf  & ~clr_err);
         ferr <= ferr_set | (ferr & ~clr_err);
      end
   end

endmodule

// File: tb/tb_result_drain.sv
module tb_result_drain;
   import tpu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr_err = 1'b0;
   logic ovf, ferr;

   result_drain_if bi();

   result_drain #(.FRAMES(2), .OUT_W(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bi),
      .clr_err (clr_err),
      .ovf     (ovf),
      .ferr    (ferr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // handshakes seen by the host: {last, idx, data}
   logic [18:0] obs_q[$];
   always @(negedge clk)
      if (rst_n && bi.out_valid && bi.out_ready)
         obs_q.push_back({bi.out_last, bi.out_idx, bi.out_data});

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put_byte(input logic first, input logic [7:0] b, input logic [1:0] m);
      bi.in_valid = 1'b1;
      bi.in_first = first;
      bi.in_byte  = b;
      bi.mode     = m;
      step();
      bi.in_valid = 1'b0;
      bi.in_first = 1'b0;
   endtask

   task automatic send_frame(input logic [63:0] f, input logic [1:0] m);
      for (int i = 0; i < 8; i++) put_byte(i == 0, f[63-8*i -: 8], m);
   endtask

   // wait for the drain to settle, then compare the whole handshake log
   task automatic expect_frames(input string tag, input logic [191:0] exp, input int nfr);
      int          n;
      logic [18:0] e;
      logic [15:0] w;
      repeat (30) step();
      n = obs_q.size();
      chk($sformatf("%s_count", tag), n, nfr * 4);
      for (int i = 0; i < n && i < nfr * 4; i++) begin
         e = obs_q[i];
         w = exp[191-16*i -: 16];
         chk($sformatf("%s_data%0d", tag, i), e[15:0], w);
         chk($sformatf("%s_idx%0d", tag, i), e[17:16], i % 4);
         chk($sformatf("%s_last%0d", tag, i), e[18], (i % 4) == 3);
      end
      obs_q.delete();
   endtask

   logic [63:0] f1, f2, f3;

   initial begin
      bi.in_valid  = 1'b0;
      bi.in_first  = 1'b0;
      bi.in_byte   = 8'h00;
      bi.mode      = 2'd0;
      bi.out_ready = 1'b1;

      // 1. reset state, then a raw frame at full rate
      step(); step();
      chk("rst_valid", bi.out_valid, 0);
      chk("rst_data",  bi.out_data,  0);
      chk("rst_idx",   bi.out_idx,   0);
      chk("rst_last",  bi.out_last,  0);
      chk("rst_ovf",   ovf,  0);
      chk("rst_ferr",  ferr, 0);
      rst_n = 1'b1;
      step();
      send_frame(64'h0102_0304_0506_0708, MODE_RAW);
      chk("t1_lat_valid", bi.out_valid, 0);
      step();
      chk("t1_v0", bi.out_valid, 1); chk("t1_d0", bi.out_data, 16'h0102);
      chk("t1_i0", bi.out_idx, 0);   chk("t1_l0", bi.out_last, 0);
      step();
      chk("t1_d1", bi.out_data, 16'h0304); chk("t1_i1", bi.out_idx, 1);
      step();
      chk("t1_d2", bi.out_data, 16'h0506); chk("t1_i2", bi.out_idx, 2);
      step();
      chk("t1_d3", bi.out_data, 16'h0708); chk("t1_i3", bi.out_idx, 3);
      chk("t1_l3", bi.out_last, 1);
      step();
      chk("t1_empty", bi.out_valid, 0);
      obs_q.delete();

      // 2. post-process modes
      send_frame(64'hFF80_0005_8000_7FFF, MODE_RELU);
      expect_frames("t2_relu", {64'h0000_0005_0000_7FFF, 128'h0}, 1);
      send_frame(64'hFF80_0005_8000_7FFF, MODE_RELU_SAT);
      expect_frames("t2_relusat", {64'h0000_0005_0000_007F, 128'h0}, 1);
      send_frame(64'hFF80_0005_8000_7FFF, MODE_SAT);
      expect_frames("t2_sat", {64'hFF80_0005_FF80_007F, 128'h0}, 1);

      // 3. back-pressure: third frame dropped on a full FIFO
      f1 = 64'h1111_2222_3333_4444;
      f2 = 64'h5555_6666_7777_0888;
      f3 = 64'h9999_AAAA_BBBB_CCCC;
      bi.out_ready = 1'b0;
      send_frame(f1, MODE_RAW);
      send_frame(f2, MODE_RAW);
      send_frame(f3, MODE_RAW);
      chk("t3_ovf", ovf, 1);
      step(); step(); step();
      chk("t3_hold_valid", bi.out_valid, 1);
      chk("t3_hold_data",  bi.out_data, 16'h1111);
      chk("t3_hold_idx",   bi.out_idx, 0);
      bi.out_ready = 1'b1;
      expect_frames("t3_drain", {f1, f2, 64'h0}, 2);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("t3_ovf_clr", ovf, 0);

      // 4. frame restart mid-collect
      for (int i = 0; i < 5; i++) put_byte(i == 0, 8'h11 * (i + 1), MODE_RAW);
      send_frame(64'hAAAB_ACAD_AEAF_B0B1, MODE_RAW);
      chk("t4_ferr", ferr, 1);
      expect_frames("t4_out", {64'hAAAB_ACAD_AEAF_B0B1, 128'h0}, 1);
      chk("t4_ovf", ovf, 0);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("t4_ferr_clr", ferr, 0);

      // 5. push into a full FIFO on the same edge the head frame is released
      f1 = 64'h1001_1002_1003_1004;
      f2 = 64'h2001_2002_2003_2004;
      f3 = 64'h3001_3002_3003_3004;
      bi.out_ready = 1'b0;
      send_frame(f1, MODE_RAW);
      send_frame(f2, MODE_RAW);
      for (int i = 0; i < 8; i++) begin
         if (i == 4) bi.out_ready = 1'b1;
         put_byte(i == 0, f3[63-8*i -: 8], MODE_RAW);
      end
      chk("t5_ovf", ovf, 0);
      expect_frames("t5_drain", {f1, f2, f3}, 3);
      chk("t5_ovf_end", ovf, 0);

      // 6. reset while draining and while collecting
      bi.out_ready = 1'b0;
      send_frame(64'h4001_4002_4003_4004, MODE_RAW);
      put_byte(1'b1, 8'h50, MODE_RAW);
      put_byte(1'b0, 8'h51, MODE_RAW);
      put_byte(1'b1, 8'h60, MODE_RAW);
      put_byte(1'b0, 8'h61, MODE_RAW);
      chk("t6_ferr_pre", ferr, 1);
      bi.out_ready = 1'b1;
      step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t6_valid", bi.out_valid, 0);
      chk("t6_data",  bi.out_data, 0);
      chk("t6_ovf",   ovf, 0);
      chk("t6_ferr",  ferr, 0);
      obs_q.delete();
      put_byte(1'b0, 8'h77, MODE_RAW);
      send_frame(64'h7001_7002_7003_7004, MODE_RELU);
      expect_frames("t6_clean", {64'h7001_7002_7003_7004, 128'h0}, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
